// File: rtl/eeprom_ram_bridge.sv
// Arbitrates the 24C0x EEPROM model and the host save-file path onto one
// synchronous backup-RAM port, and tracks EEPROM writes with a dirty flag.
module eeprom_ram_bridge #(
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ee_addr,
  input  logic [7:0]        ee_wdata,
  input  logic              ee_read,
  input  logic              ee_write,
  output logic [7:0]        ee_rdata,
  output logic              ee_done,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_rd,
  input  logic              host_wr,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              dirty,
  input  logic              clear_dirty
);

  typedef enum logic [2:0] {
    IDLE, EE_WR, EE_RD, EE_DONE, H_WR, H_RD, H_ACK
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t            state;
  logic              pend_valid;
  logic              pend_wr;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_wdata;
  logic [2:0]        cnt;

  // A strobe arriving in IDLE with an empty slot is serviced directly, so the
  // host still beats an EEPROM request raised in the same cycle.
  logic              host_req;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

  always_comb begin
    host_req  = pend_valid | host_rd | host_wr;
    sel_wr    = host_wr;
    sel_addr  = host_addr;
    sel_wdata = host_wdata;
    if (pend_valid) begin
      sel_wr    = pend_wr;
      sel_addr  = pend_addr;
      sel_wdata = pend_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      cnt        <= '0;
      ee_rdata   <= '0;
      ee_done    <= 1'b0;
      host_rdata <= '0;
      host_ack   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      dirty      <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      host_ack <= 1'b0;
      if (clear_dirty) dirty <= 1'b0;

      if (!pend_valid && (host_rd || host_wr)) begin
        pend_valid <= 1'b1;
        pend_wr    <= host_wr;
        pend_addr  <= host_addr;
        pend_wdata <= host_wdata;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (host_req) begin
            mem_addr <= sel_addr;
            if (sel_wr) begin
              mem_wdata <= sel_wdata;
              mem_we    <= 1'b1;
              state     <= H_WR;
            end else begin
              state <= H_RD;
            end
          end else if (ee_write) begin
            mem_addr  <= ee_addr;
            mem_wdata <= ee_wdata;
            mem_we    <= 1'b1;
            state     <= EE_WR;
          end else if (ee_read) begin
            mem_addr <= ee_addr;
            state    <= EE_RD;
          end
        end
        EE_WR: begin
          // Set overrides a coincident clear_dirty.
          dirty   <= 1'b1;
          ee_done <= 1'b1;
          state   <= EE_DONE;
        end
        EE_RD: begin
          if (cnt == LAT) begin
            ee_rdata <= mem_rdata;
            ee_done  <= 1'b1;
            state    <= EE_DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        EE_DONE: begin
          if (!ee_read && !ee_write) begin
            ee_done <= 1'b0;
            state   <= IDLE;
          end
        end
        H_WR: begin
          host_ack <= 1'b1;
          state    <= H_ACK;
        end
        H_RD: begin
          if (cnt == LAT) begin
            host_rdata <= mem_rdata;
            host_ack   <= 1'b1;
            state      <= H_ACK;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        H_ACK: begin
          pend_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_ram_bridge.sv
// Directed bench for eeprom_ram_bridge with a behavioural synchronous RAM
// whose read data trails the registered address by RD_LAT cycles.
module tb_eeprom_ram_bridge;

  localparam int AW     = 8;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ee_addr;
  logic [7:0]    ee_wdata;
  logic          ee_read, ee_write;
  logic [7:0]    ee_rdata;
  logic          ee_done;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_rd, host_wr;
  logic [7:0]    host_rdata;
  logic          host_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic          dirty;
  logic          clear_dirty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eeprom_ram_bridge #(.ADDR_W(AW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .ee_addr(ee_addr), .ee_wdata(ee_wdata), .ee_read(ee_read), .ee_write(ee_write),
    .ee_rdata(ee_rdata), .ee_done(ee_done),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rd(host_rd), .host_wr(host_wr),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .dirty(dirty), .clear_dirty(clear_dirty)
  );

  // RAM model with preload port
  logic [7:0]    ram [0:255];
  logic [AW-1:0] pipe [0:RD_LAT-1];
  logic          pre_we = 1'b0;
  logic [7:0]    pre_addr = '0;
  logic [7:0]    pre_data = '0;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
    pipe[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = ram[pipe[RD_LAT-1]];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({ee_done, host_ack, mem_we, dirty} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {ee_done, host_ack, mem_we, dirty});
    end
    checks++;
    if ({ee_rdata, host_rdata, mem_addr, mem_wdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 00000000", {ee_rdata, host_rdata, mem_addr, mem_wdata});
    end
    reset = 1'b0;
    tick();
    $display("reset: flags=%b", {ee_done, host_ack, mem_we, dirty});
  endtask

  task automatic test_ee_write();
    ee_addr = 8'h3C; ee_wdata = 8'hA5; ee_write = 1'b1;
    tick();
    checks++;
    if ({mem_we, mem_addr, mem_wdata, ee_done} !== {1'b1, 8'h3C, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL ee_wr_c1 got we=%b a=%h d=%h done=%b want we=1 a=3c d=a5 done=0",
               mem_we, mem_addr, mem_wdata, ee_done);
    end
    tick();
    checks++;
    if ({ee_done, mem_we, dirty} !== 3'b101) begin
      errors++;
      $display("FAIL ee_wr_c2 got done/we/dirty=%b want 101", {ee_done, mem_we, dirty});
    end
    tick();
    checks++;
    if (ee_done !== 1'b1) begin
      errors++;
      $display("FAIL ee_wr_hold got done=%b want 1", ee_done);
    end
    ee_write = 1'b0;
    tick();
    checks++;
    if (ee_done !== 1'b0) begin
      errors++;
      $display("FAIL ee_wr_drop got done=%b want 0", ee_done);
    end
    $display("ee_write: a=3c d=a5 dirty=%b", dirty);
  endtask

  task automatic test_ee_read();
    int saw_we = 0;
    int held = 1;
    preload(8'h10, 8'h5A);
    ee_addr = 8'h10; ee_read = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (mem_we) saw_we++;
    end
    checks++;
    if (ee_done !== 1'b0) begin
      errors++;
      $display("FAIL ee_rd_early got done=%b at cycle 3 want 0", ee_done);
    end
    tick();
    if (mem_we) saw_we++;
    checks++;
    if ({ee_done, ee_rdata} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL ee_rd_c4 got done=%b data=%h want done=1 data=5a", ee_done, ee_rdata);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ee_done !== 1'b1) held = 0;
      if (mem_we) saw_we++;
    end
    checks++;
    if (held != 1) begin
      errors++;
      $display("FAIL ee_rd_hold got done dropped want held 10 cycles");
    end
    checks++;
    if (saw_we != 0) begin
      errors++;
      $display("FAIL ee_rd_no_we got %0d write cycles want 0", saw_we);
    end
    ee_read = 1'b0;
    tick();
    checks++;
    if (ee_done !== 1'b0) begin
      errors++;
      $display("FAIL ee_rd_drop got done=%b want 0", ee_done);
    end
    clear_dirty = 1'b1;
    tick();
    clear_dirty = 1'b0;
    checks++;
    if (dirty !== 1'b0) begin
      errors++;
      $display("FAIL dirty_clear got %b want 0", dirty);
    end
    $display("ee_read: a=10 data=%h", ee_rdata);
  endtask

  task automatic test_contention();
    int acks = 0;
    int done_cyc = -1;
    preload(8'h01, 8'h77);
    host_addr = 8'h00; host_wdata = 8'h11; host_wr = 1'b1;
    ee_addr = 8'h01; ee_read = 1'b1;
    tick();
    host_wr = 1'b0;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h00, 8'h11}) begin
      errors++;
      $display("FAIL cont_host_first got we=%b a=%h d=%h want we=1 a=00 d=11",
               mem_we, mem_addr, mem_wdata);
    end
    for (int c = 2; c <= 20 && done_cyc < 0; c++) begin
      tick();
      if (host_ack) acks++;
      if (ee_done) done_cyc = c;
    end
    checks++;
    if (done_cyc != 7) begin
      errors++;
      $display("FAIL cont_ee_latency got cycle %0d want 7", done_cyc);
    end
    checks++;
    if (ee_rdata !== 8'h77) begin
      errors++;
      $display("FAIL cont_ee_data got %h want 77", ee_rdata);
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL cont_ack_count got %0d want 1", acks);
    end
    checks++;
    if (dirty !== 1'b0) begin
      errors++;
      $display("FAIL cont_dirty got %b want 0", dirty);
    end
    ee_read = 1'b0;
    tick(); tick();
    $display("contention: host wr 00<-11 then ee rd 01=%h", ee_rdata);
  endtask

  task automatic test_host_overrun();
    int acks = 0;
    int ack_cyc = -1;
    int saw21 = 0;
    preload(8'h20, 8'hC3);
    preload(8'h21, 8'h3C);
    host_addr = 8'h20; host_rd = 1'b1;
    tick();
    host_addr = 8'h21;
    tick();
    host_rd = 1'b0;
    for (int c = 2; c <= 15; c++) begin
      if (mem_addr == 8'h21) saw21++;
      if (host_ack) begin
        acks++;
        ack_cyc = c;
      end
      tick();
    end
    checks++;
    if (acks != 1 || ack_cyc != 4) begin
      errors++;
      $display("FAIL ovr_ack got %0d acks at cycle %0d want 1 at 4", acks, ack_cyc);
    end
    checks++;
    if (host_rdata !== 8'hC3) begin
      errors++;
      $display("FAIL ovr_data got %h want c3", host_rdata);
    end
    checks++;
    if (saw21 != 0) begin
      errors++;
      $display("FAIL ovr_dropped got %0d accesses to 21 want 0", saw21);
    end
    $display("host_overrun: rdata=%h acks=%0d", host_rdata, acks);
  endtask

  task automatic test_dirty_race();
    ee_addr = 8'h40; ee_wdata = 8'h99; ee_write = 1'b1;
    tick();
    clear_dirty = 1'b1;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL race_we got %b want 1", mem_we);
    end
    tick();
    ee_write = 1'b0;
    checks++;
    if (dirty !== 1'b1) begin
      errors++;
      $display("FAIL race_set_wins got %b want 1", dirty);
    end
    tick();
    clear_dirty = 1'b0;
    checks++;
    if (dirty !== 1'b0) begin
      errors++;
      $display("FAIL race_clear got %b want 0", dirty);
    end
    tick();
    $display("dirty_race: dirty=%b", dirty);
  endtask

  task automatic test_reset_mid_read();
    int done_cyc = -1;
    ee_addr = 8'h10; ee_read = 1'b1;
    tick();
    checks++;
    if (mem_addr !== 8'h10) begin
      errors++;
      $display("FAIL rst_rd_addr got %h want 10", mem_addr);
    end
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({ee_done, host_ack, mem_we, dirty, ee_rdata, host_rdata, mem_addr, mem_wdata} !== 36'h0) begin
      errors++;
      $display("FAIL rst_mid got %h want 0",
               {ee_done, host_ack, mem_we, dirty, ee_rdata, host_rdata, mem_addr, mem_wdata});
    end
    reset = 1'b0; ee_read = 1'b0;
    tick();
    ee_addr = 8'h3C; ee_read = 1'b1;
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      tick();
      if (ee_done) done_cyc = c;
    end
    checks++;
    if (done_cyc != 4 || ee_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rst_fresh_read got cycle %0d data %h want cycle 4 data a5", done_cyc, ee_rdata);
    end
    ee_read = 1'b0;
    tick();
    $display("reset_mid_read: fresh rdata=%h", ee_rdata);
  endtask

  initial begin
    reset = 1'b1;
    ee_addr = '0; ee_wdata = '0; ee_read = 1'b0; ee_write = 1'b0;
    host_addr = '0; host_wdata = '0; host_rd = 1'b0; host_wr = 1'b0;
    clear_dirty = 1'b0;
    test_reset();
    test_ee_write();
    test_ee_read();
    test_contention();
    test_host_overrun();
    test_dirty_race();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eeprom_ram_bridge.md
Name: eeprom_ram_bridge

Overview:
- Downstream stage of the 24C0x serial EEPROM model: services its ram_read/ram_write request lines against a shared synchronous backup-RAM port.
- Also gives the host save-file path (load/store of the .sav image) access to the same RAM.
- Tracks a dirty flag so the save-file writer knows when EEPROM contents have changed.
- Runs every clk, not gated by ce, so the EEPROM model always sees completion on a later ce cycle.

Parameters:
ADDR_W, 8, RAM address width (256 bytes covers 24C01 and 24C02)
RD_LATENCY, 2, cycles from mem_addr registered to mem_rdata valid (1..7)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ee_addr  in  ADDR_W  EEPROM request address
ee_wdata  in  8  EEPROM write data
ee_read  in  1  EEPROM read request, level, held until ee_done seen
ee_write  in  1  EEPROM write request, level, held until ee_done seen
ee_rdata  out  8  read data returned to EEPROM
ee_done  out  1  completion, level
host_addr  in  ADDR_W  host save-file address
host_wdata  in  8  host write data
host_rd  in  1  host read strobe, 1 cycle
host_wr  in  1  host write strobe, 1 cycle
host_rdata  out  8  host read data
host_ack  out  1  host completion pulse, 1 cycle
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  8  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  8  RAM read data
dirty  out  1  set by EEPROM write since last clear
clear_dirty  in  1  clears dirty

Behaviour:
- Reset values: all outputs 0 (ee_rdata, host_rdata, mem_addr, mem_wdata also 0); state IDLE; host pending latch cleared; dirty cleared.
- Reset mid-access: abandon the access; mem_we drops immediately.
- States: IDLE, EE_WR, EE_RD, EE_DONE, H_WR, H_RD, H_ACK.
- Host strobes: host_rd/host_wr latch into a one-deep pending slot (address, data, direction) in any state.
- A strobe arriving while the slot is occupied is dropped. The host must wait for host_ack.
- If host_rd and host_wr are asserted together, host_wr wins.
- IDLE arbitration: pending host beats an EEPROM request. Either access, once started, is never preempted.
- IDLE -> H_WR / EE_WR (write request), in the cycle after the request is seen:
  - mem_addr and mem_wdata are registered from the request; mem_we is 1 for exactly one cycle.
- IDLE -> H_RD / EE_RD (read request), in the cycle after the request is seen:
  - mem_addr is registered; mem_we is 0.
  - A counter waits RD_LATENCY cycles, then mem_rdata is captured into host_rdata / ee_rdata.
- If both ee_read and ee_write are high, ee_write wins.
- EEPROM latency, counting request-seen as cycle 0:
  - Write: mem_we at cycle 1; ee_done at cycle 2.
  - Read: ee_rdata valid and ee_done at cycle 2+RD_LATENCY.
- EE_DONE: ee_done is held high until both ee_read and ee_write are low. ee_done drops the next cycle, then the block returns to IDLE.
  - This guarantees the ce-gated EEPROM samples done.
- Host latency: after H_WR or read capture, go to H_ACK. host_ack is 1 for one cycle, the pending slot is cleared, then return to IDLE.
- ee_rdata and host_rdata hold their last value until the next read of the same side.
- dirty:
  - Set in the cycle mem_we is issued for an EEPROM write. Host writes never set it.
  - clear_dirty clears it.
  - If clear_dirty and an EEPROM write's mem_we occur in the same cycle, set wins.
- Address width: addresses pass through unmodified. The 24C01 128-byte fold is done upstream.
- Back-to-back EEPROM requests are legal once ee_done has dropped. A new request seen in IDLE starts normally.

Test Plan:
- EEPROM write: ee_write=1, ee_addr=0x3C, ee_wdata=0xA5 -> cycle 1 mem_we=1, mem_addr=0x3C, mem_wdata=0xA5; ee_done at cycle 2; dirty=1; ee_done falls one cycle after ee_write drops.
- EEPROM read with RD_LATENCY=2: RAM[0x10]=0x5A, ee_read=1, ee_addr=0x10 -> ee_rdata=0x5A and ee_done=1 at cycle 4; no mem_we; ee_done held while ee_read stays high for 10 more cycles.
- Contention: host_wr strobe (0x00←0x11) and ee_read (0x01) asserted in the same cycle -> host write first, one host_ack pulse; then EEPROM read completes; dirty stays 0.
- Host overrun: host_rd to 0x20, then host_rd to 0x21 before host_ack -> exactly one ack, host_rdata=RAM[0x20]; second strobe dropped, no access to 0x21.
- Dirty race: clear_dirty coincident with an EEPROM write mem_we -> dirty=1; clear_dirty alone next cycle -> dirty=0.
- Reset mid-read: assert reset one cycle after mem_addr is issued -> next cycle all outputs 0, state IDLE; a fresh ee_read completes with normal latency.
